// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer: arbitrates two requesters onto one 32-bit ALU and splits
// rotates into passes of at most 7 bits.              Revision: 1.0
// ============================================================================
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    input  logic        r1_valid,
    output logic        r0_ready,
    output logic        r1_ready,
    input  logic [4:0]  r0_sel,
    input  logic [4:0]  r1_sel,
    input  logic [31:0] r0_a,
    input  logic [31:0] r1_a,
    input  logic [31:0] r0_b,
    input  logic [31:0] r1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic [31:0] alu_i1,
    output logic [31:0] alu_i2,
    output logic [4:0]  alu_sel,
    input  logic [31:0] alu_o,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [4:0] C_MAX_STEP = 5'd7;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        id_q, id_d;
    logic [4:0]  sel_q, sel_d;
    logic [4:0]  rem_q, rem_d;
    logic [31:0] a_q, a_d;
    logic [31:0] acc_q, acc_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_zero_q, rsp_zero_d;

    logic        w_grant1;
    logic        w_grant_any;
    logic        w_is_rot;
    logic        w_last;
    logic [4:0]  w_step;
    logic [4:0]  w_rem_left;

    // Requester 1 wins when it is alone or when the priority bit names it.
    assign w_grant1    = r1_valid && (!r0_valid || prio_q);
    assign w_grant_any = r0_valid || r1_valid;
    assign r0_ready    = (state_q == S_IDLE) && r0_valid && !w_grant1;
    assign r1_ready    = (state_q == S_IDLE) && w_grant1;

    assign w_is_rot   = (sel_q[4:1] == 4'd0);
    assign w_step     = (rem_q > C_MAX_STEP) ? C_MAX_STEP : rem_q;
    assign w_rem_left = rem_q - w_step;
    assign w_last     = !w_is_rot || (w_rem_left == 5'd0);

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

    always_comb begin
        alu_i1  = 32'd0;
        alu_i2  = 32'd0;
        alu_sel = 5'd0;
        if (state_q == S_EXEC) begin
            alu_sel = sel_q;
            alu_i2  = acc_q;
            alu_i1  = w_is_rot ? {27'd0, w_step} : a_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        id_d        = id_q;
        sel_d       = sel_q;
        rem_d       = rem_q;
        a_d         = a_q;
        acc_d       = acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        case (state_q)
            S_IDLE: begin
                if (w_grant_any) begin
                    id_d    = w_grant1;
                    prio_d  = !w_grant1;
                    sel_d   = w_grant1 ? r1_sel : r0_sel;
                    a_d     = w_grant1 ? r1_a : r0_a;
                    acc_d   = w_grant1 ? r1_b : r0_b;
                    rem_d   = w_grant1 ? r1_a[4:0] : r0_a[4:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // acc carries the partially rotated word between passes
                if (w_is_rot) begin
                    acc_d = alu_o;
                    rem_d = w_rem_left;
                end
                if (w_last) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = alu_o;
                    rsp_zero_d  = alu_zero;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            id_q        <= 1'b0;
            sel_q       <= 5'd0;
            rem_q       <= 5'd0;
            a_q         <= 32'd0;
            acc_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            id_q        <= id_d;
            sel_q       <= sel_d;
            rem_q       <= rem_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_alu_sequencer: scoreboard bench with an ALU model and reference model.
// Revision: 1.0
// ============================================================================
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [4:0]  r0_sel, r1_sel;
    logic [31:0] r0_a, r1_a, r0_b, r1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_data;
    logic [31:0] alu_i1, alu_i2, alu_o;
    logic [4:0]  alu_sel;
    logic        alu_zero;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        zero;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    logic grants[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic prio_m;
    logic done0, done1;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_sel(r0_sel), .r1_sel(r1_sel),
        .r0_a(r0_a), .r1_a(r1_a), .r0_b(r0_b), .r1_b(r1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_sel(alu_sel),
        .alu_o(alu_o), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] rot(input logic left, input logic [31:0] d, input logic [4:0] n);
        logic [63:0] t;
        t = {d, d};
        if (left) begin
            t = t << n;
            return t[63:32];
        end
        t = t >> n;
        return t[31:0];
    endfunction

    // ALU under control: rotates refuse amounts above 7 by producing junk.
    function automatic logic [31:0] alu_fn(input logic [4:0] s, input logic [31:0] i1, input logic [31:0] i2);
        case (s)
            5'd0:    return (i1 > 32'd7) ? (i2 ^ 32'hDEADBEEF) : rot(1'b1, i2, i1[4:0]);
            5'd1:    return (i1 > 32'd7) ? (i2 ^ 32'hDEADBEEF) : rot(1'b0, i2, i1[4:0]);
            5'd16:   return i1 + i2;
            5'd17:   return i1 - i2;
            5'd18:   return i1 & i2;
            5'd19:   return i1 | i2;
            5'd20:   return i1 ^ i2;
            default: return i1 + (i2 ^ {27'd0, s});
        endcase
    endfunction

    always_comb begin
        alu_o    = alu_fn(alu_sel, alu_i1, alu_i2);
        alu_zero = (alu_o == 32'd0);
    end

    function automatic logic [31:0] ref_result(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        if (s == 5'd0) return rot(1'b1, b, a[4:0]);
        if (s == 5'd1) return rot(1'b0, b, a[4:0]);
        return alu_fn(s, a, b);
    endfunction

    function automatic int passes(input logic [4:0] s, input logic [31:0] a);
        if (s > 5'd1) return 1;
        if (a[4:0] == 5'd0) return 1;
        return (int'(a[4:0]) + 6) / 7;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not seen (got none, expected one)", name);
    endtask

    // Monitor: models grants, pushes expectations, checks every response.
    initial begin
        logic        pv, pid, pzero, prdy, g;
        logic [31:0] pdata;
        exp_t        e;
        pv = 1'b0; pid = 1'b0; pzero = 1'b0; prdy = 1'b0; pdata = 32'd0;
        prio_m = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                prio_m = 1'b0;
                exp_q.delete();
                continue;
            end
            if (r0_ready || r1_ready) begin
                g = r1_ready;
                check("dual_ready", {31'd0, r0_ready && r1_ready}, 32'd0);
                check("ready_in_resp", {31'd0, rsp_valid}, 32'd0);
                if (r0_valid && r1_valid)
                    check("arb_choice", {31'd0, g}, {31'd0, prio_m});
                e.id   = g;
                e.data = g ? ref_result(r1_sel, r1_a, r1_b) : ref_result(r0_sel, r0_a, r0_b);
                e.zero = (e.data == 32'd0);
                e.due  = cyc + 1 + (g ? passes(r1_sel, r1_a) : passes(r0_sel, r0_a));
                exp_q.push_back(e);
                grants.push_back(g);
                prio_m = !g;
            end
            if (rsp_valid) begin
                check("alu_idle_sel", {27'd0, alu_sel}, 32'd0);
                check("alu_idle_i1", alu_i1, 32'd0);
            end
            if (rsp_valid && !pv) begin
                if (exp_q.size() == 0) flag("spurious_rsp");
                else check("latency", cyc, exp_q[0].due);
            end
            if (pv && !prdy) begin
                check("hold_valid", {31'd0, rsp_valid}, 32'd1);
                check("hold_data", rsp_data, pdata);
                check("hold_id", {31'd0, rsp_id}, {31'd0, pid});
                check("hold_zero", {31'd0, rsp_zero}, {31'd0, pzero});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) flag("rsp_without_req");
                else begin
                    e = exp_q.pop_front();
                    check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
                end
            end
            pv = rsp_valid; pid = rsp_id; pdata = rsp_data; pzero = rsp_zero; prdy = rsp_ready;
        end
    end

    task automatic drive(input int id, input logic v, input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            r0_valid = v; r0_sel = s; r0_a = a; r0_b = b;
        end else begin
            r1_valid = v; r1_sel = s; r1_a = a; r1_b = b;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic req(input int id, input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        logic got;
        got = 1'b0;
        drive(id, 1'b1, s, a, b);
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            got = (id == 0) ? r0_ready : r1_ready;
        end
        if (!got) flag("grant_timeout");
        else begin
            @(posedge clk);
            #1;
        end
        drive(id, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic rand_req(input int id);
        logic [4:0]  s;
        logic [31:0] a, b;
        int          r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    s = r[4:0];
            2:       s = 5'd16;
            3:       s = 5'd17;
            4:       s = 5'd18;
            5:       s = 5'd19;
            6:       s = 5'd20;
            7:       s = 5'($urandom_range(2, 15));
            default: s = 5'($urandom_range(0, 31));
        endcase
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        req(id, s, a, b);
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        if (!rsp_valid) flag(name);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) flag("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        drive(0, 1'b0, 5'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        done0 = 1'b0; done1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id_zero", {30'd0, rsp_id, rsp_zero}, 32'd0);
        check("rst_alu", alu_i1 | alu_i2 | {27'd0, alu_sel}, 32'd0);
        check("rst_ready", {30'd0, r0_ready, r1_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single add
        req(0, 5'd16, 32'h5, 32'hA);
        wait_rsp("add_rsp");
        check("add_data", rsp_data, 32'h0000000F);
        check("add_id", {31'd0, rsp_id}, 32'd0);
        wait_idle();

        // long rotate left by 20: passes 7, 7, 6
        req(1, 5'd0, 32'd20, 32'h80000001);
        check("pass1_i1", alu_i1, 32'd7);
        @(posedge clk); #1;
        check("pass2_i1", alu_i1, 32'd7);
        @(posedge clk); #1;
        check("pass3_i1", alu_i1, 32'd6);
        wait_rsp("rotl_rsp");
        check("rotl_data", rsp_data, 32'h00180000);
        check("rotl_id", {31'd0, rsp_id}, 32'd1);
        wait_idle();

        // max rotate right, then zero amount
        req(0, 5'd1, 32'd31, 32'h1);
        wait_rsp("rotr31_rsp");
        check("rotr31_data", rsp_data, 32'h00000002);
        wait_idle();
        req(0, 5'd1, 32'd0, 32'h12345678);
        check("rot0_i1", alu_i1, 32'd0);
        wait_rsp("rot0_rsp");
        check("rot0_data", rsp_data, 32'h12345678);
        wait_idle();

        // contention from a fresh reset
        do_reset();
        grants.delete();
        fork
            begin repeat (2) req(0, 5'd16, $urandom, $urandom); end
            begin repeat (2) req(1, 5'd16, $urandom, $urandom); end
        join
        wait_idle();
        if (grants.size() != 4) check("grant_count", grants.size(), 32'd4);
        else for (int i = 0; i < 4; i++) check("grant_order", {31'd0, grants[i]}, i % 2);

        // backpressure for 5 cycles with requester 1 waiting
        rsp_ready = 1'b0;
        req(0, 5'd17, 32'd77, 32'd77);
        wait_rsp("bp_rsp");
        check("bp_zero", {31'd0, rsp_zero}, 32'd1);
        drive(1, 1'b1, 5'd18, 32'hF0F0F0F0, 32'h0FF00FF0);
        repeat (5) begin
            @(negedge clk);
            check("bp_no_ready", {30'd0, r0_ready, r1_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_cycle_ready", {31'd0, r1_ready}, 32'd0);
        @(negedge clk);
        check("bp_idle_ready", {31'd0, r1_ready}, 32'd1);
        @(posedge clk); #1;
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        wait_idle();

        // reset during the second pass of a 31-bit rotate
        req(0, 5'd0, 32'd31, 32'hA5A5A5A5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_alu", alu_i1 | alu_i2 | {27'd0, alu_sel}, 32'd0);
        check("abort_rsp_data", rsp_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        drive(0, 1'b1, 5'd16, 32'd1, 32'd2);
        drive(1, 1'b1, 5'd16, 32'd3, 32'd4);
        @(negedge clk);
        check("abort_prio", {30'd0, r0_ready, r1_ready}, 32'd2);
        @(posedge clk); #1;
        drive(0, 1'b0, 5'd0, 32'd0, 32'd0);
        wait_idle();
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        wait_idle();

        // randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    rand_req(0);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
                done0 = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    rand_req(1);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
                done1 = 1'b1;
            end
            begin
                while (!(done0 && done1)) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
